// File: rtl/execute_memory_pipe_pkg.sv
// Shared encodings for the EX->MEM register
// and its store-alignment helper.
package execute_memory_pipe_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/execute_memory_pipe_align.sv
// Store-lane alignment: byte enables, replicated
// store data and misalignment detection.
module store_align
  import execute_memory_pipe_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]    size,
  input  logic [1:0]    addr,
  input  logic [DW-1:0] sd,
  input  logic          mem_read,
  input  logic          mem_write,
  output logic [3:0]    be,
  output logic [DW-1:0] data,
  output logic          misaligned
);

  // Decode access size into lanes; non-memory ops get no lanes
  always_comb begin
    be         = BE_NONE;
    data       = sd;
    misaligned = 1'b0;
    unique case (size)
      SZ_BYTE: begin
        be   = 4'b0001 << addr;
        data = {(DW/8){sd[7:0]}};
      end
      SZ_HALF: begin
        be         = 4'b0011 << {addr[1], 1'b0};
        data       = {(DW/16){sd[15:0]}};
        misaligned = addr[0];
      end
      SZ_WORD: begin
        be         = BE_WORD;
        misaligned = |addr;
      end
      default: misaligned = 1'b1;
    endcase
    if (!(mem_read || mem_write)) begin
      be         = BE_NONE;
      misaligned = 1'b0;
    end
  end

endmodule

// File: rtl/execute_memory_pipe.sv
// EX->MEM pipeline register with store alignment,
// MEM-stage bypass source and load-use hazard detect.
module execute_memory_pipe
  import execute_memory_pipe_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [DATA_WIDTH-1:0] ex_ALU_result,
  input  logic [DATA_WIDTH-1:0] ex_store_data,
  input  logic [4:0]            ex_rd,
  input  logic                  ex_regWrite,
  input  logic                  ex_memRead,
  input  logic                  ex_memWrite,
  input  logic [2:0]            ex_funct3,
  input  logic [4:0]            ex_rs1,
  input  logic [4:0]            ex_rs2,
  output logic                  mem_valid,
  output logic [DATA_WIDTH-1:0] mem_ALU_result,
  output logic [DATA_WIDTH-1:0] mem_store_data,
  output logic [3:0]            mem_byte_en,
  output logic [4:0]            mem_rd,
  output logic                  mem_regWrite,
  output logic                  mem_memRead,
  output logic                  mem_memWrite,
  output logic [2:0]            mem_funct3,
  output logic                  mem_misaligned,
  output logic                  bypass_valid,
  output logic [4:0]            bypass_rd,
  output logic [DATA_WIDTH-1:0] bypass_data,
  output logic                  load_hazard,
  input  logic                  report
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] alu_q, alu_d;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
  logic [3:0]            be_q, be_d;
  logic [4:0]            rd_q, rd_d;
  logic                  rw_q, rw_d;
  logic                  mr_q, mr_d;
  logic                  mw_q, mw_d;
  logic [2:0]            f3_q, f3_d;
  logic                  mis_q, mis_d;
  logic [31:0]           cyc_q, cyc_d;

  logic [3:0]            al_be;
  logic [DATA_WIDTH-1:0] al_data;
  logic                  al_mis;

  store_align #(
    .DW (DATA_WIDTH)
  ) u_align (
    .size       (ex_funct3[1:0]),
    .addr       (ex_ALU_result[1:0]),
    .sd         (ex_store_data),
    .mem_read   (ex_memRead),
    .mem_write  (ex_memWrite),
    .be         (al_be),
    .data       (al_data),
    .misaligned (al_mis)
  );

  // Next state: flush beats stall beats load; misaligned ops keep only the trap info
  always_comb begin
    valid_d = valid_q;
    alu_d   = alu_q;
    sdata_d = sdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    f3_d    = f3_q;
    mis_d   = mis_q;
    cyc_d   = cyc_q + 32'd1;
    if (flush || (!stall && !ex_valid)) begin
      valid_d = 1'b0;
      alu_d   = '0;
      sdata_d = '0;
      be_d    = BE_NONE;
      rd_d    = '0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      f3_d    = '0;
      mis_d   = 1'b0;
    end else if (!stall) begin
      valid_d = 1'b1;
      alu_d   = ex_ALU_result;
      sdata_d = al_data;
      be_d    = al_mis ? BE_NONE : al_be;
      rd_d    = ex_rd;
      rw_d    = ex_regWrite & ~al_mis;
      mr_d    = ex_memRead & ~al_mis;
      mw_d    = ex_memWrite & ~al_mis;
      f3_d    = ex_funct3;
      mis_d   = al_mis;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      sdata_q <= '0;
      be_q    <= BE_NONE;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      f3_q    <= '0;
      mis_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      valid_q <= valid_d;
      alu_q   <= alu_d;
      sdata_q <= sdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      f3_q    <= f3_d;
      mis_q   <= mis_d;
      cyc_q   <= cyc_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_ALU_result = alu_q;
  assign mem_store_data = sdata_q;
  assign mem_byte_en    = be_q;
  assign mem_rd         = rd_q;
  assign mem_regWrite   = rw_q;
  assign mem_memRead    = mr_q;
  assign mem_memWrite   = mw_q;
  assign mem_funct3     = f3_q;
  assign mem_misaligned = mis_q;

  assign bypass_valid = valid_q & rw_q & ~mr_q & (rd_q != 5'd0);
  assign bypass_rd    = rd_q;
  assign bypass_data  = alu_q;

  assign load_hazard = valid_q & mr_q & (rd_q != 5'd0)
                     & ((rd_q == ex_rs1) | (rd_q == ex_rs2));

`ifndef SYNTHESIS
  logic [ADDRESS_BITS-1:0] rpt_addr;
  assign rpt_addr = ADDRESS_BITS'(alu_q);

  // Per-cycle trace of the MEM stage contents
  always_ff @(posedge clock) begin
    if (report)
      $display("core%0d cyc=%0d v=%b a=%h res=%h sd=%h be=%b rd=%0d rw=%b mr=%b mw=%b f3=%b mis=%b",
               CORE, cyc_q, valid_q, rpt_addr, alu_q, sdata_q, be_q,
               rd_q, rw_q, mr_q, mw_q, f3_q, mis_q);
  end
`endif

endmodule

// File: tb/tb_execute_memory_pipe.sv
// Self-checking bench for execute_memory_pipe:
// vector table through a scoreboard plus hand sequences.
module tb_execute_memory_pipe;
  import execute_memory_pipe_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall, flush, ex_valid;
  logic [31:0] ex_ALU_result, ex_store_data;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic        ex_regWrite, ex_memRead, ex_memWrite;
  logic [2:0]  ex_funct3;
  logic        report;

  logic        mem_valid;
  logic [31:0] mem_ALU_result, mem_store_data;
  logic [3:0]  mem_byte_en;
  logic [4:0]  mem_rd;
  logic        mem_regWrite, mem_memRead, mem_memWrite;
  logic [2:0]  mem_funct3;
  logic        mem_misaligned;
  logic        bypass_valid;
  logic [4:0]  bypass_rd;
  logic [31:0] bypass_data;
  logic        load_hazard;

  execute_memory_pipe #(
    .CORE         (0),
    .DATA_WIDTH   (32),
    .ADDRESS_BITS (20)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_ALU_result  (ex_ALU_result),
    .ex_store_data  (ex_store_data),
    .ex_rd          (ex_rd),
    .ex_regWrite    (ex_regWrite),
    .ex_memRead     (ex_memRead),
    .ex_memWrite    (ex_memWrite),
    .ex_funct3      (ex_funct3),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .mem_valid      (mem_valid),
    .mem_ALU_result (mem_ALU_result),
    .mem_store_data (mem_store_data),
    .mem_byte_en    (mem_byte_en),
    .mem_rd         (mem_rd),
    .mem_regWrite   (mem_regWrite),
    .mem_memRead    (mem_memRead),
    .mem_memWrite   (mem_memWrite),
    .mem_funct3     (mem_funct3),
    .mem_misaligned (mem_misaligned),
    .bypass_valid   (bypass_valid),
    .bypass_rd      (bypass_rd),
    .bypass_data    (bypass_data),
    .load_hazard    (load_hazard),
    .report         (report)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        vld;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic        e_vld;
    logic [31:0] e_alu;
    logic [31:0] e_sd;
    logic [3:0]  e_be;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic        e_mr;
    logic        e_mw;
    logic [2:0]  e_f3;
    logic        e_mis;
    logic        e_bv;
    logic        e_lh;
  } vec_t;

  typedef struct {
    string        nm;
    logic [119:0] v;
  } sb_t;

  vec_t tbl [14];
  sb_t  sbq [$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [119:0] obs;
  assign obs = {mem_valid, mem_ALU_result, mem_store_data, mem_byte_en,
                mem_rd, mem_regWrite, mem_memRead, mem_memWrite,
                mem_funct3, mem_misaligned, bypass_valid, bypass_rd,
                bypass_data, load_hazard};

  function automatic logic [119:0] exp_of(input vec_t v);
    return {v.e_vld, v.e_alu, v.e_sd, v.e_be, v.e_rd, v.e_rw, v.e_mr,
            v.e_mw, v.e_f3, v.e_mis, v.e_bv, v.e_rd, v.e_alu, v.e_lh};
  endfunction

  task automatic check(input string nm, input logic [119:0] act,
                       input logic [119:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic pop_check();
    sb_t e;
    if (sbq.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard: got %h expected <empty queue>", obs);
    end else begin
      e = sbq.pop_front();
      check(e.nm, obs, e.v);
    end
  endtask

  task automatic apply(input vec_t v);
    ex_valid      = v.vld;
    ex_ALU_result = v.alu;
    ex_store_data = v.sd;
    ex_rd         = v.rd;
    ex_rs1        = v.rs1;
    ex_rs2        = v.rs2;
    ex_regWrite   = v.rw;
    ex_memRead    = v.mr;
    ex_memWrite   = v.mw;
    ex_funct3     = v.f3;
  endtask

  // Called at a negedge; returns at the following negedge
  task automatic drive_vec(input vec_t v, input string nm);
    apply(v);
    sbq.push_back('{nm, exp_of(v)});
    @(posedge clock);
    #1;
    pop_check();
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [119:0] held;

    tbl[0]  = '{1, 32'h1003, 32'h11223344, 5'd0, 5'd1, 5'd1, 0, 0, 1, F3_SB,
                1, 32'h1003, 32'h44444444, 4'b1000, 5'd0, 0, 0, 1, F3_SB, 0, 0, 0};
    tbl[1]  = '{1, 32'h1002, 32'h11223344, 5'd0, 5'd1, 5'd1, 0, 0, 1, F3_SH,
                1, 32'h1002, 32'h33443344, 4'b1100, 5'd0, 0, 0, 1, F3_SH, 0, 0, 0};
    tbl[2]  = '{1, 32'h1001, 32'h11223344, 5'd0, 5'd1, 5'd1, 0, 0, 1, F3_SH,
                1, 32'h1001, 32'h33443344, 4'b0000, 5'd0, 0, 0, 0, F3_SH, 1, 0, 0};
    tbl[3]  = '{1, 32'h1004, 32'hCAFEF00D, 5'd0, 5'd1, 5'd1, 0, 0, 1, F3_SW,
                1, 32'h1004, 32'hCAFEF00D, 4'b1111, 5'd0, 0, 0, 1, F3_SW, 0, 0, 0};
    tbl[4]  = '{1, 32'h1006, 32'hCAFEF00D, 5'd0, 5'd1, 5'd1, 0, 0, 1, F3_SW,
                1, 32'h1006, 32'hCAFEF00D, 4'b0000, 5'd0, 0, 0, 0, F3_SW, 1, 0, 0};
    tbl[5]  = '{1, 32'h2001, 32'h000000A5, 5'd9, 5'd1, 5'd1, 1, 1, 0, F3_LBU,
                1, 32'h2001, 32'hA5A5A5A5, 4'b0010, 5'd9, 1, 1, 0, F3_LBU, 0, 0, 0};
    tbl[6]  = '{1, 32'h0000DEAD, 32'h0, 5'd5, 5'd1, 5'd2, 1, 0, 0, 3'b000,
                1, 32'h0000DEAD, 32'h0, 4'b0000, 5'd5, 1, 0, 0, 3'b000, 0, 1, 0};
    tbl[7]  = '{1, 32'h0000DEAD, 32'h0, 5'd0, 5'd1, 5'd2, 1, 0, 0, 3'b000,
                1, 32'h0000DEAD, 32'h0, 4'b0000, 5'd0, 1, 0, 0, 3'b000, 0, 0, 0};
    tbl[8]  = '{1, 32'h1235, 32'h0, 5'd6, 5'd1, 5'd2, 1, 0, 0, 3'b011,
                1, 32'h1235, 32'h0, 4'b0000, 5'd6, 1, 0, 0, 3'b011, 0, 1, 0};
    tbl[9]  = '{1, 32'h3000, 32'h0, 5'd8, 5'd1, 5'd2, 1, 1, 0, 3'b011,
                1, 32'h3000, 32'h0, 4'b0000, 5'd8, 0, 0, 0, 3'b011, 1, 0, 0};
    tbl[10] = '{0, 32'h5555, 32'h6666, 5'd9, 5'd9, 5'd9, 1, 1, 1, F3_LW,
                0, 32'h0, 32'h0, 4'b0000, 5'd0, 0, 0, 0, 3'b000, 0, 0, 0};
    tbl[11] = '{1, 32'h3002, 32'h0, 5'd10, 5'd10, 5'd2, 1, 1, 0, F3_LH,
                1, 32'h3002, 32'h0, 4'b1100, 5'd10, 1, 1, 0, F3_LH, 0, 0, 1};
    tbl[12] = '{1, 32'h3004, 32'h0, 5'd0, 5'd0, 5'd0, 1, 1, 0, F3_LW,
                1, 32'h3004, 32'h0, 4'b1111, 5'd0, 1, 1, 0, F3_LW, 0, 0, 0};
    tbl[13] = '{1, 32'h4000, 32'h0, 5'd7, 5'd1, 5'd1, 1, 1, 0, F3_LW,
                1, 32'h4000, 32'h0, 4'b1111, 5'd7, 1, 1, 0, F3_LW, 0, 0, 0};

    report = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
    reset  = 1'b0;
    ex_valid      = 1'b1;
    ex_ALU_result = $urandom;
    ex_store_data = $urandom;
    ex_rd         = 5'($urandom_range(1, 31));
    ex_rs1        = ex_rd;
    ex_rs2        = ex_rd;
    ex_regWrite   = 1'b1;
    ex_memRead    = 1'b1;
    ex_memWrite   = 1'b1;
    ex_funct3     = F3_LW;

    repeat (3) @(posedge clock);
    #1;
    check("reset_state", obs, '0);

    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 14; i++)
      drive_vec(tbl[i], $sformatf("vec%0d", i));

    ex_rs1 = 5'd3;
    ex_rs2 = 5'd7;
    #1;
    check("hazard_rs2", 120'({load_hazard, bypass_valid}), 120'(2'b10));
    ex_rs1 = 5'd3;
    ex_rs2 = 5'd3;
    #1;
    check("hazard_none", 120'({load_hazard, bypass_valid}), 120'(2'b00));

    held = exp_of(tbl[13]);
    @(negedge clock);
    stall = 1'b1;
    apply(tbl[6]);
    ex_rs1 = 5'd3;
    ex_rs2 = 5'd3;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      check($sformatf("stall_hold%0d", c), obs, held);
    end

    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    check("stall_flush_bubble", obs, '0);

    @(negedge clock);
    flush = 1'b0;
    stall = 1'b0;
    drive_vec(tbl[6], "reload_alu");

    stall = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("reset_mid_stall", obs, '0);
    @(negedge clock);
    reset = 1'b1;
    stall = 1'b0;
    drive_vec(tbl[3], "first_after_reset");

    if (sbq.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d expected 0 entries", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
